// File: rtl/spi_slave_ram.sv
// spi_slave_ram: word-addressed RAM behind an SPI slave front end.
// Each 10-bit word from the deserialiser carries a 2-bit command and an
// 8-bit payload. The four commands are: load write address, write data,
// load read address, and read data. Read data returns on dout with a
// one-cycle tx_valid strobe.
module spi_slave_ram #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [7:0]           dout,
  output logic                 tx_valid
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // Storage has no reset. Its contents survive rst_n.
  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  cmd_e                 cmd;

  assign cmd = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);

  // Memory write. This is gated by rst_n so that a reset cycle
  // suppresses any write word that arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n && rx_valid && cmd == CMD_WR_DATA)
      mem[wr_addr] <= din[7:0];
  end

  // Command decode: update the address registers and the registered read port.
  // dout is only updated by a read-data word or by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
    end else if (!rx_valid) begin
      tx_valid <= 1'b0;
    end else begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr  <= din[ADDR_SIZE-1:0];
          tx_valid <= 1'b0;
        end
        CMD_WR_DATA: begin
          tx_valid <= 1'b0;
        end
        CMD_RD_ADDR: begin
          rd_addr  <= din[ADDR_SIZE-1:0];
          tx_valid <= 1'b0;
        end
        CMD_RD_DATA: begin
          dout     <= mem[rd_addr];
          tx_valid <= 1'b1;
        end
        default: tx_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_ram.sv
// tb_spi_slave_ram: scoreboard bench for spi_slave_ram.
// Inputs are driven after the falling edge. A reference model updates at
// each rising edge and pushes the expected outputs into a queue. Each
// scenario task pops that queue and compares against the DUT at the
// following falling edge.
module tb_spi_slave_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  spi_slave_ram #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic       tx;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state.
  logic [7:0] m_mem [256];
  logic [7:0] m_wa, m_ra, m_dout;
  logic       m_tx;

  // Drive one cycle, advance the model at posedge, optionally queue the expectation.
  task automatic step(input bit r, input bit v, input logic [9:0] d, input bit chk);
    rst_n = r; rx_valid = v; din = d;
    @(posedge clk);
    if (!r) begin
      m_wa = 8'h00; m_ra = 8'h00; m_dout = 8'h00; m_tx = 1'b0;
    end else if (!v) begin
      m_tx = 1'b0;
    end else begin
      case (d[9:8])
        2'b00: begin m_wa = d[7:0]; m_tx = 1'b0; end
        2'b01: begin m_mem[m_wa] = d[7:0]; m_tx = 1'b0; end
        2'b10: begin m_ra = d[7:0]; m_tx = 1'b0; end
        default: begin m_dout = m_mem[m_ra]; m_tx = 1'b1; end
      endcase
    end
    if (chk) exp_q.push_back('{dout: m_dout, tx: m_tx});
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 10'h000, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'h00 || tx_valid !== 1'b0 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL reset_idle: dout=%h tx=%b want dout=00 tx=0", dout, tx_valid);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 10'h3A5, 1'b1);
      e = exp_q.pop_front(); n_cmp++;
      if (dout !== 8'h00 || tx_valid !== 1'b0 || dout !== e.dout || tx_valid !== e.tx) begin
        n_err++; $display("FAIL reset_over_read: dout=%h tx=%b want dout=00 tx=0", dout, tx_valid);
      end
    end
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 10'h03A, 1'b0);
    step(1'b1, 1'b1, 10'h15C, 1'b0);
    step(1'b1, 1'b1, 10'h23A, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (tx_valid !== e.tx || dout !== e.dout) begin
      n_err++; $display("FAIL wr_no_tx: dout=%h tx=%b want dout=%h tx=%b", dout, tx_valid, e.dout, e.tx);
    end
    step(1'b1, 1'b1, 10'h300, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'h5C || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL wr_rd_5c: dout=%h tx=%b want dout=5c tx=1", dout, tx_valid);
    end
    step(1'b1, 1'b0, 10'h000, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'h5C || tx_valid !== 1'b0 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL tx_pulse_end: dout=%h tx=%b want dout=5c tx=0", dout, tx_valid);
    end
  endtask

  task automatic test_independent_addr();
    step(1'b1, 1'b1, 10'h010, 1'b0);
    step(1'b1, 1'b1, 10'h1AA, 1'b0);
    step(1'b1, 1'b1, 10'h020, 1'b0);
    step(1'b1, 1'b1, 10'h1BB, 1'b0);
    step(1'b1, 1'b1, 10'h210, 1'b0);
    step(1'b1, 1'b1, 10'h300, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'hAA || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL indep_rd10: dout=%h tx=%b want dout=aa tx=1", dout, tx_valid);
    end
    step(1'b1, 1'b1, 10'h220, 1'b0);
    step(1'b1, 1'b1, 10'h3FF, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'hBB || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL indep_rd20: dout=%h tx=%b want dout=bb tx=1", dout, tx_valid);
    end
  endtask

  task automatic test_idle();
    // rd_addr=0x20, wr_addr=0x20 here; idle words of every command must be ignored.
    logic [9:0] idle_words [4] = '{10'h010, 10'h111, 10'h210, 10'h3FF};
    foreach (idle_words[i]) begin
      step(1'b1, 1'b0, idle_words[i], 1'b1);
      e = exp_q.pop_front(); n_cmp++;
      if (dout !== 8'hBB || tx_valid !== 1'b0 || dout !== e.dout || tx_valid !== e.tx) begin
        n_err++; $display("FAIL idle_hold[%0d]: dout=%h tx=%b want dout=bb tx=0", i, dout, tx_valid);
      end
    end
    step(1'b1, 1'b1, 10'h300, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'hBB || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL idle_mem_kept: dout=%h tx=%b want dout=bb tx=1", dout, tx_valid);
    end
    // The write address must still be 0x20: a data word lands there, not at 0x10.
    step(1'b1, 1'b1, 10'h166, 1'b0);
    step(1'b1, 1'b1, 10'h300, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'h66 || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL idle_wa_kept: dout=%h tx=%b want dout=66 tx=1", dout, tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    // Write immediately followed by a read of the same address.
    step(1'b1, 1'b1, 10'h177, 1'b0);
    step(1'b1, 1'b1, 10'h300, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'h77 || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL raw_same_addr: dout=%h tx=%b want dout=77 tx=1", dout, tx_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 10'h3C3, 1'b1);
      e = exp_q.pop_front(); n_cmp++;
      if (dout !== 8'h77 || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
        n_err++; $display("FAIL b2b_read[%0d]: dout=%h tx=%b want dout=77 tx=1", i, dout, tx_valid);
      end
    end
  endtask

  task automatic test_reset_persist();
    step(1'b1, 1'b1, 10'h000, 1'b0);
    step(1'b1, 1'b1, 10'h1FF, 1'b0);
    step(1'b1, 1'b1, 10'h210, 1'b0);
    step(1'b0, 1'b1, 10'h3FF, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'h00 || tx_valid !== 1'b0 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL persist_reset: dout=%h tx=%b want dout=00 tx=0", dout, tx_valid);
    end
    step(1'b1, 1'b1, 10'h200, 1'b0);
    step(1'b1, 1'b1, 10'h300, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (dout !== 8'hFF || tx_valid !== 1'b1 || dout !== e.dout || tx_valid !== e.tx) begin
      n_err++; $display("FAIL persist_read: dout=%h tx=%b want dout=ff tx=1", dout, tx_valid);
    end
  endtask

  task automatic test_random();
    int cov [4];
    int errs = 0;
    // Fill every address first so no read ever returns undefined contents.
    for (int a = 0; a < 256; a++) begin
      step(1'b1, 1'b1, {2'b00, 8'(a)}, 1'b0);
      step(1'b1, 1'b1, {2'b01, 8'($urandom_range(255))}, 1'b0);
    end
    for (int i = 0; i < 10000; i++) begin
      bit         r, v;
      logic [1:0] c;
      logic [7:0] p;
      int         sel;
      r   = ($urandom_range(99) != 0);
      v   = ($urandom_range(9) != 0);
      c   = 2'($urandom_range(3));
      sel = $urandom_range(3);
      p   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(255));
      if (r && v) cov[c]++;
      step(r, v, {c, p}, 1'b1);
      e = exp_q.pop_front(); n_cmp++;
      if (dout !== e.dout || tx_valid !== e.tx) begin
        n_err++; errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: dout=%h tx=%b want dout=%h tx=%b", i, dout, tx_valid, e.dout, e.tx);
      end
    end
    n_cmp++;
    if (cov[0] == 0 || cov[1] == 0 || cov[2] == 0 || cov[3] == 0) begin
      n_err++; $display("FAIL random_cmd_cover: counts=%0d/%0d/%0d/%0d want all nonzero",
                        cov[0], cov[1], cov[2], cov[3]);
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    m_wa = '0; m_ra = '0; m_dout = '0; m_tx = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_independent_addr();
    test_idle();
    test_back_to_back();
    test_reset_persist();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
